// File: rtl/rx_image_loader_pkg.sv
// Shared types and constants for the UART image loader: state encoding,
// DRAM address width and the default UART bit period.
package rx_image_loader_pkg;

  localparam int unsigned ADDR_W           = 20;
  localparam int unsigned DEF_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Bits needed to hold a bit-timer value in the range 0..clks.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return $clog2(clks + 1);
  endfunction

endpackage

// File: rtl/rx_image_loader_uart_rx_core.sv
// 8N1 UART receiver: input synchroniser, bit timer, LSB-first shift register
// and START/DATA/STOP sequencing. Emits a one-cycle byte_valid or frame_err.
module uart_rx_core
  import rx_image_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned        CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]   FULL  = CNT_W'(CLKS_PER_BIT);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;
  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_ferr;
  logic             w_fall;
  logic             w_tick;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_sync3 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!i_en) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_fall) w_next = ST_START;
        ST_START: if (w_tick) w_next = r_sync2 ? ST_IDLE : ST_DATA;
        ST_DATA:  if (w_tick && (r_bit == 3'd7)) w_next = ST_STOP;
        ST_STOP:  if (w_tick) w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_fall = r_sync3 & ~r_sync2;
    w_tick = (r_cnt == CNT_W'(1));
    o_busy = (r_state != ST_IDLE);
  end

  // Timer is preloaded with half a bit while idle so the start bit is sampled mid-bit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= HALF;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if ((r_state == ST_IDLE) || !i_en) begin
        r_cnt <= HALF;
        r_bit <= '0;
      end else if (w_tick) begin
        r_cnt <= FULL;
        if (r_state == ST_DATA) begin
          r_shift <= {r_sync2, r_shift[7:1]};
          r_bit   <= r_bit + 3'd1;
        end
        if (r_state == ST_STOP) begin
          r_valid <= r_sync2;
          r_ferr  <= ~r_sync2;
        end
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_valid;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/rx_image_loader.sv
// Receive stage: writes each UART byte to consecutive DRAM addresses and
// raises end_receive once a full image has been stored.
module rx_image_loader
  import rx_image_loader_pkg::*;
#(
  parameter int unsigned       CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned       IMAGE_BYTES  = 65536,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en_com,
  input  logic              rx,
  output logic [ADDR_W-1:0] rx_dm,
  output logic [7:0]        data_out_rx,
  output logic              rx_wr,
  output logic              rd_rx,
  output logic              frame_err,
  output logic              rx_busy,
  output logic              end_receive
);

  localparam int unsigned      CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMAGE_BYTES - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_count;
  logic [7:0]        r_data;
  logic              w_core_en;
  logic              w_byte_valid;
  logic              w_core_ferr;
  logic              w_core_busy;
  logic              w_last;
  logic [7:0]        w_byte;

  assign w_last    = (r_count == LAST_CNT);
  // Keep the receiver off while the final write retires so DONE ignores rx.
  assign w_core_en = en_com && (r_state != ST_DONE) && !((r_state == ST_WRITE) && w_last);

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .i_clk        (clock),
    .i_reset      (reset),
    .i_en         (w_core_en),
    .i_rx         (rx),
    .o_byte       (w_byte),
    .o_byte_valid (w_byte_valid),
    .o_frame_err  (w_core_ferr),
    .o_busy       (w_core_busy)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!en_com) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (w_byte_valid) w_next = ST_WRITE;
        ST_WRITE: w_next = w_last ? ST_DONE : ST_IDLE;
        ST_DONE:  w_next = ST_DONE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_wr       = (r_state == ST_WRITE);
    rd_rx       = (r_state == ST_WRITE);
    end_receive = (r_state == ST_DONE);
    rx_busy     = w_core_busy | w_byte_valid | (r_state == ST_WRITE);
    frame_err   = w_core_ferr;
    rx_dm       = r_addr;
    data_out_rx = r_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
      r_data  <= '0;
    end else if (!en_com) begin
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_byte_valid) begin
        r_data <= w_byte;
      end
      if (r_state == ST_WRITE) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rx_image_loader.sv
// Directed bench for rx_image_loader with a write scoreboard (CLKS_PER_BIT=8, 4-byte image).
module tb_rx_image_loader;

  typedef struct packed {
    logic [19:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_com;
  logic        rx;
  logic [19:0] rx_dm;
  logic [7:0]  data_out_rx;
  logic        rx_wr;
  logic        rd_rx;
  logic        frame_err;
  logic        rx_busy;
  logic        end_receive;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   wr_count = 0;
  int   rd_count = 0;
  int   ferr_count = 0;
  int   wr_cyc = 0;
  int   er_rise_cyc = -1;
  int   t0;
  logic prev_er = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  rx_image_loader #(
    .CLKS_PER_BIT(8),
    .IMAGE_BYTES (4),
    .BASE_ADDR   (20'd0)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .en_com      (en_com),
    .rx          (rx),
    .rx_dm       (rx_dm),
    .data_out_rx (data_out_rx),
    .rx_wr       (rx_wr),
    .rd_rx       (rd_rx),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy),
    .end_receive (end_receive)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rx_dm"},       32'(rx_dm),       32'd0);
    check({pfx, "_data"},        32'(data_out_rx), 32'd0);
    check({pfx, "_rx_wr"},       32'(rx_wr),       32'd0);
    check({pfx, "_rd_rx"},       32'(rd_rx),       32'd0);
    check({pfx, "_frame_err"},   32'(frame_err),   32'd0);
    check({pfx, "_rx_busy"},     32'(rx_busy),     32'd0);
    check({pfx, "_end_receive"}, 32'(end_receive), 32'd0);
  endtask

  // action: 0 normal, 1 drop en_com at frame bit 'at', 2 pulse reset at 'at', 3 frame sent while DONE
  task automatic send(input logic [7:0] b, input logic stop, input int action, input int at);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      if (i == at && action == 1) en_com = 1'b0;
      if (i == at && action == 2) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("rst_mid");
        repeat (7) @(negedge clk);
      end else begin
        if (i == 4 && action == 0) check("busy_mid_frame", 32'(rx_busy), 32'd1);
        if (i == 4 && action == 3) check("busy_while_done", 32'(rx_busy), 32'd0);
        repeat (8) @(negedge clk);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rx_wr === 1'b1) begin
      wr_count++;
      wr_cyc = cyc;
      check("wr_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(rx_dm), 32'(mon_e.addr));
        check("wr_data", 32'(data_out_rx), 32'(mon_e.data));
        check("wr_rd_rx", 32'(rd_rx), 32'd1);
      end
    end
    if (rd_rx === 1'b1) rd_count++;
    if (frame_err === 1'b1) ferr_count++;
    if (end_receive === 1'b1 && prev_er === 1'b0) er_rise_cyc = cyc;
    prev_er = end_receive;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    en_com = 1'b0;
    rx     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("reset");

    // Single byte with exact latency
    en_com = 1'b1;
    repeat (4) @(negedge clk);
    sb.push_back('{addr: 20'd0, data: 8'hA5});
    t0 = cyc + 1;
    send(8'hA5, 1'b1, 0, -1);
    repeat (4) @(negedge clk);
    check("t1_latency", 32'(wr_cyc - t0), 32'd79);
    check("t1_wr_count", 32'(wr_count), 32'd1);
    check("t1_end_receive", 32'(end_receive), 32'd0);
    check("t1_rx_dm_next", 32'(rx_dm), 32'd1);
    en_com = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_rx_dm_cleared", 32'(rx_dm), 32'd0);
    en_com = 1'b1;
    repeat (2) @(negedge clk);

    // Back-to-back full image
    sb.push_back('{addr: 20'd0, data: 8'h01});
    sb.push_back('{addr: 20'd1, data: 8'h02});
    sb.push_back('{addr: 20'd2, data: 8'h03});
    sb.push_back('{addr: 20'd3, data: 8'hFF});
    send(8'h01, 1'b1, 0, -1);
    send(8'h02, 1'b1, 0, -1);
    send(8'h03, 1'b1, 0, -1);
    send(8'hFF, 1'b1, 0, -1);
    repeat (4) @(negedge clk);
    check("t2_wr_count", 32'(wr_count), 32'd5);
    check("t2_end_receive", 32'(end_receive), 32'd1);
    check("t2_er_rise_cycle", 32'(er_rise_cyc), 32'(wr_cyc + 1));
    send(8'h77, 1'b1, 3, -1);
    repeat (4) @(negedge clk);
    check("t2_done_ignores_rx", 32'(wr_count), 32'd5);
    check("t2_end_receive_held", 32'(end_receive), 32'd1);
    check("t2_rx_dm_held", 32'(rx_dm), 32'd4);
    en_com = 1'b0;
    check("t2_er_same_cycle", 32'(end_receive), 32'd1);
    @(negedge clk);
    check("t2_er_cleared", 32'(end_receive), 32'd0);
    check("t2_rx_dm_base", 32'(rx_dm), 32'd0);
    en_com = 1'b1;
    repeat (2) @(negedge clk);

    // Start glitch
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_busy_in_start", 32'(rx_busy), 32'd1);
    repeat (10) @(negedge clk);
    check("t3_busy_after", 32'(rx_busy), 32'd0);
    check("t3_no_write", 32'(wr_count), 32'd5);
    check("t3_no_ferr", 32'(ferr_count), 32'd0);
    check("t3_rx_dm", 32'(rx_dm), 32'd0);

    // Framing error then good byte
    send(8'h3C, 1'b0, 0, -1);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    check("t4_ferr_pulse", 32'(ferr_count), 32'd1);
    check("t4_no_write", 32'(wr_count), 32'd5);
    check("t4_rx_dm", 32'(rx_dm), 32'd0);
    sb.push_back('{addr: 20'd0, data: 8'h55});
    send(8'h55, 1'b1, 0, -1);
    repeat (4) @(negedge clk);
    check("t4_wr_count", 32'(wr_count), 32'd6);
    check("t4_rx_dm_next", 32'(rx_dm), 32'd1);

    // en_com dropped during second byte
    en_com = 1'b0;
    @(negedge clk);
    en_com = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back('{addr: 20'd0, data: 8'h11});
    send(8'h11, 1'b1, 0, -1);
    send(8'h22, 1'b1, 1, 4);
    repeat (4) @(negedge clk);
    check("t5_no_write", 32'(wr_count), 32'd7);
    check("t5_rx_dm_reset", 32'(rx_dm), 32'd0);
    check("t5_busy", 32'(rx_busy), 32'd0);
    en_com = 1'b1;
    repeat (2) @(negedge clk);
    sb.push_back('{addr: 20'd0, data: 8'h33});
    send(8'h33, 1'b1, 0, -1);
    repeat (4) @(negedge clk);
    check("t5_wr_count", 32'(wr_count), 32'd8);
    check("t5_rx_dm_next", 32'(rx_dm), 32'd1);

    // Reset during DATA; remaining bits of 0xF0 are high so no false start follows
    send(8'hF0, 1'b1, 2, 5);
    repeat (4) @(negedge clk);
    check("t6_no_write", 32'(wr_count), 32'd8);
    sb.push_back('{addr: 20'd0, data: 8'h66});
    send(8'h66, 1'b1, 0, -1);
    repeat (4) @(negedge clk);
    check("t6_wr_count", 32'(wr_count), 32'd9);
    check("t6_rx_dm_next", 32'(rx_dm), 32'd1);
    check("t6_data_held", 32'(data_out_rx), 32'h66);

    check("end_sb_empty", 32'(sb.size()), 32'd0);
    check("end_rd_eq_wr", 32'(rd_count), 32'(wr_count));
    check("end_ferr_total", 32'(ferr_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
